// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU FSM encodings,
// the pipeline NOP word and the bundled stall/flush control vector.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_BUSY = 2'd1,
        MDU_ST_DONE = 2'd2
    } mdu_state_t;

    // sll $0,$0,0 -- what the flush paths load into a pipeline register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_NONE   = '0;
    localparam hazard_ctl_t CTL_MEM    = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                           stall_ex_mem: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0,
                                           flush_mem_wb: 1'b1};
    localparam hazard_ctl_t CTL_BRANCH = '{stall_pc: 1'b0, stall_if_id: 1'b0, stall_id_ex: 1'b0,
                                           stall_ex_mem: 1'b0, flush_if_id: 1'b1, flush_id_ex: 1'b1,
                                           flush_mem_wb: 1'b0};
    localparam hazard_ctl_t CTL_BUBBLE = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b0,
                                           stall_ex_mem: 1'b0, flush_if_id: 1'b0, flush_id_ex: 1'b1,
                                           flush_mem_wb: 1'b0};

    // Initial counter value for an MDU op lasting `cycles` EX-stage cycles.
    function automatic int mdu_load_value(input int cycles);
        return cycles - 2;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_sequencer.sv
// MDU sequencer: IDLE/BUSY/DONE FSM with a down-counter; owns mdu_busy and
// the one-cycle mdu_done pulse. Ops are never cancelled once started.
module mdu_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(mdu_load_value(MUL_CYCLES));
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(mdu_load_value(DIV_CYCLES));

    mdu_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] load_val;
    logic             busy_reg, done_reg;

    assign load_val = is_div ? DIV_LOAD : MUL_LOAD;

    // The counter holds the number of BUSY cycles still to run, so the FSM
    // lands in DONE exactly (cycles - 1) cycles after the start cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            MDU_ST_IDLE, MDU_ST_DONE: begin
                state_next = MDU_ST_IDLE;
                if (start) begin
                    cnt_next   = load_val;
                    state_next = (load_val == '0) ? MDU_ST_DONE : MDU_ST_BUSY;
                end
            end
            MDU_ST_BUSY: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = MDU_ST_DONE;
                end
            end
            default: begin
                state_next = MDU_ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MDU_ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != MDU_ST_IDLE);
            done_reg  <= (state_next == MDU_ST_DONE);
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: priority logic for memory wait, taken
// branch, load-use and MDU hazards. Optional counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        useRs_ID,
    input  logic        useRt_ID,
    input  logic        hiloUse_ID,
    input  logic        ctrlMemRead_ID_EX,
    input  logic [4:0]  rd_ID_EX,
    input  logic        mdu_start,
    input  logic        mdu_isDiv,
    input  logic        ctrlMemAccess_EX_MEM,
    input  logic        dmem_ready,
    input  logic        branchTaken_EX,
    output logic        stall_PC,
    output logic        stall_IF_ID,
    output logic        stall_ID_EX,
    output logic        stall_EX_MEM,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_MEM_WB,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stallCycles,
    output logic [31:0] perf_flushCount,
`endif
    output logic        mdu_busy,
    output logic        mdu_done
);

    logic        mem_stall;
    logic        load_use;
    logic        mdu_stall;
    hazard_ctl_t ctl;

    mdu_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mdu_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .is_div (mdu_isDiv),
        .busy   (mdu_busy),
        .done   (mdu_done)
    );

    assign mem_stall = ctrlMemAccess_EX_MEM & ~dmem_ready;
    assign load_use  = ctrlMemRead_ID_EX & (rd_ID_EX != 5'd0)
                     & ((useRs_ID & (rd_ID_EX == rs_ID)) | (useRt_ID & (rd_ID_EX == rt_ID)));
    // mdu_busy is high exactly when the FSM is out of IDLE (BUSY or DONE).
    assign mdu_stall = hiloUse_ID & (mdu_busy | mdu_start);

    // Memory wait freezes everything, deferring a taken branch held in EX.
    always_comb begin
        ctl = CTL_NONE;
        if (!rst_n)
            ctl = CTL_NONE;
        else if (mem_stall)
            ctl = CTL_MEM;
        else if (branchTaken_EX)
            ctl = CTL_BRANCH;
        else if (load_use || mdu_stall)
            ctl = CTL_BUBBLE;
    end

    assign stall_PC     = ctl.stall_pc;
    assign stall_IF_ID  = ctl.stall_if_id;
    assign stall_ID_EX  = ctl.stall_id_ex;
    assign stall_EX_MEM = ctl.stall_ex_mem;
    assign flush_IF_ID  = ctl.flush_if_id;
    assign flush_ID_EX  = ctl.flush_id_ex;
    assign flush_MEM_WB = ctl.flush_mem_wb;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stall_PC)
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if (flush_IF_ID)
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stallCycles = perf_stall_reg;
    assign perf_flushCount  = perf_flush_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_ID, rt_ID, rd_ID_EX;
    logic        useRs_ID, useRt_ID, hiloUse_ID, ctrlMemRead_ID_EX;
    logic        mdu_start, mdu_isDiv, ctrlMemAccess_EX_MEM, dmem_ready, branchTaken_EX;
    logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    logic        flush_IF_ID, flush_ID_EX, flush_MEM_WB;
    logic        mdu_busy, mdu_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stallCycles, perf_flushCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX, flush_MEM_WB}
    localparam logic [6:0] EXP_NONE   = 7'b0000000;
    localparam logic [6:0] EXP_BUBBLE = 7'b1100010;
    localparam logic [6:0] EXP_MEM    = 7'b1111001;
    localparam logic [6:0] EXP_BRANCH = 7'b0000110;

    hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rs_ID                (rs_ID),
        .rt_ID                (rt_ID),
        .useRs_ID             (useRs_ID),
        .useRt_ID             (useRt_ID),
        .hiloUse_ID           (hiloUse_ID),
        .ctrlMemRead_ID_EX    (ctrlMemRead_ID_EX),
        .rd_ID_EX             (rd_ID_EX),
        .mdu_start            (mdu_start),
        .mdu_isDiv            (mdu_isDiv),
        .ctrlMemAccess_EX_MEM (ctrlMemAccess_EX_MEM),
        .dmem_ready           (dmem_ready),
        .branchTaken_EX       (branchTaken_EX),
        .stall_PC             (stall_PC),
        .stall_IF_ID          (stall_IF_ID),
        .stall_ID_EX          (stall_ID_EX),
        .stall_EX_MEM         (stall_EX_MEM),
        .flush_IF_ID          (flush_IF_ID),
        .flush_ID_EX          (flush_ID_EX),
        .flush_MEM_WB         (flush_MEM_WB),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stallCycles     (perf_stallCycles),
        .perf_flushCount      (perf_flushCount),
`endif
        .mdu_busy             (mdu_busy),
        .mdu_done             (mdu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_vec();
        return {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                flush_IF_ID, flush_ID_EX, flush_MEM_WB};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        rs_ID = 5'd0; rt_ID = 5'd0; rd_ID_EX = 5'd0;
        useRs_ID = 1'b0; useRt_ID = 1'b0; hiloUse_ID = 1'b0; ctrlMemRead_ID_EX = 1'b0;
        mdu_start = 1'b0; mdu_isDiv = 1'b0;
        ctrlMemAccess_EX_MEM = 1'b0; dmem_ready = 1'b1; branchTaken_EX = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ctrlMemRead_ID_EX = 1'b1; rd_ID_EX = rd; rs_ID = rd; useRs_ID = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int done_seen;
        clear_inputs();
        rst_n = 1'b1;
        #2;
        // Reset: outputs forced low even with a live load-use condition.
        set_load_use(5'd3);
        rst_n = 1'b0;
        #1;
        check_eq("reset_ctl", 32'(ctl_vec()), 32'(EXP_NONE));
        check_eq("reset_busy", 32'(mdu_busy), 32'd0);
        check_eq("reset_done", 32'(mdu_done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_inputs();

        // Load-use: one bubble, then clear.
        tick(); set_load_use(5'd3); #1;
        check_eq("lu_rs3", 32'(ctl_vec()), 32'(EXP_BUBBLE));
        tick(); clear_inputs(); #1;
        check_eq("lu_after", 32'(ctl_vec()), 32'(EXP_NONE));
        tick(); set_load_use(5'd0); #1;
        check_eq("lu_r0", 32'(ctl_vec()), 32'(EXP_NONE));
        tick(); clear_inputs(); ctrlMemRead_ID_EX = 1'b1; rd_ID_EX = 5'd5; rt_ID = 5'd5; useRt_ID = 1'b1; #1;
        check_eq("lu_rt5", 32'(ctl_vec()), 32'(EXP_BUBBLE));
        tick(); clear_inputs(); ctrlMemRead_ID_EX = 1'b1; rd_ID_EX = 5'd7; rs_ID = 5'd7; #1;
        check_eq("lu_rs_unused", 32'(ctl_vec()), 32'(EXP_NONE));
        tick(); clear_inputs(); rd_ID_EX = 5'd7; rs_ID = 5'd7; useRs_ID = 1'b1; #1;
        check_eq("lu_not_load", 32'(ctl_vec()), 32'(EXP_NONE));

        // MULT with MFLO waiting in ID: stall T..T+3, done only at T+3.
        tick(); clear_inputs(); mdu_start = 1'b1; hiloUse_ID = 1'b1; #1;
        check_eq("mul_t0_ctl", 32'(ctl_vec()), 32'(EXP_BUBBLE));
        check_eq("mul_t0_busy", 32'(mdu_busy), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(); mdu_start = 1'b0; hiloUse_ID = 1'b1; #1;
            check_eq($sformatf("mul_t%0d_busy", k), 32'(mdu_busy), (k <= 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("mul_t%0d_done", k), 32'(mdu_done), (k == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("mul_t%0d_ctl", k), 32'(ctl_vec()),
                     (k <= 3) ? 32'(EXP_BUBBLE) : 32'(EXP_NONE));
        end

        // DIV: done exactly 31 cycles after start, memStall mid-op does not shift it.
        tick(); clear_inputs(); mdu_start = 1'b1; mdu_isDiv = 1'b1; #1;
        check_eq("div_t0_busy", 32'(mdu_busy), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            tick(); clear_inputs();
            if (k >= 10 && k <= 12) begin
                ctrlMemAccess_EX_MEM = 1'b1; dmem_ready = 1'b0;
            end
            #1;
            check_eq($sformatf("div_t%0d_busy", k), 32'(mdu_busy), (k <= 31) ? 32'd1 : 32'd0);
            check_eq($sformatf("div_t%0d_done", k), 32'(mdu_done), (k == 31) ? 32'd1 : 32'd0);
            if (k == 10)
                check_eq("div_memstall_ctl", 32'(ctl_vec()), 32'(EXP_MEM));
        end

        // Back-to-back MULT issued in the DONE cycle.
        tick(); clear_inputs(); mdu_start = 1'b1; #1;
        for (int k = 1; k <= 7; k++) begin
            tick(); clear_inputs(); mdu_start = (k == 3); #1;
            check_eq($sformatf("b2b_t%0d_busy", k), 32'(mdu_busy), (k <= 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b_t%0d_done", k), 32'(mdu_done), (k == 3 || k == 6) ? 32'd1 : 32'd0);
        end

        // Simultaneous events.
        tick(); clear_inputs(); set_load_use(5'd9); branchTaken_EX = 1'b1; #1;
        check_eq("br_over_lu", 32'(ctl_vec()), 32'(EXP_BRANCH));
        tick(); ctrlMemAccess_EX_MEM = 1'b1; dmem_ready = 1'b0; #1;
        check_eq("mem_over_br", 32'(ctl_vec()), 32'(EXP_MEM));
        tick(); dmem_ready = 1'b1; #1;
        check_eq("br_after_mem", 32'(ctl_vec()), 32'(EXP_BRANCH));
        tick(); clear_inputs(); hiloUse_ID = 1'b1; #1;
        check_eq("hilo_idle", 32'(ctl_vec()), 32'(EXP_NONE));

        // Reset mid-DIV: async clear, then no stray mdu_done.
        tick(); clear_inputs(); mdu_start = 1'b1; mdu_isDiv = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); clear_inputs();
        end
        #2;
        set_load_use(5'd4);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(mdu_busy), 32'd0);
        check_eq("rst_mid_ctl", 32'(ctl_vec()), 32'(EXP_NONE));
        tick();
        tick();
        rst_n = 1'b1;
        clear_inputs();

        // Three stall cycles and one branch flush, then idle while watching for mdu_done.
        done_seen = 0;
        for (int k = 0; k < 44; k++) begin
            tick(); clear_inputs();
            if (k < 3) set_load_use(5'd4);
            if (k == 3) branchTaken_EX = 1'b1;
            #1;
            if (mdu_done) done_seen++;
        end
        check_eq("rst_no_done", 32'(done_seen), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("perf_stall", perf_stallCycles, 32'd3);
        check_eq("perf_flush", perf_flushCount, 32'd1);
`endif

        // Fresh MULT after reset runs full latency.
        tick(); clear_inputs(); mdu_start = 1'b1; #1;
        for (int k = 1; k <= 4; k++) begin
            tick(); clear_inputs(); #1;
            check_eq($sformatf("post_t%0d_done", k), 32'(mdu_done), (k == 3) ? 32'd1 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
